alu_muldiv: RTL
===============

# alu_muldiv

Parametrised sequential successor to the single-cycle MIPS ALU. It executes the full R-type integer set: logic, add/sub with signed overflow, and signed/unsigned set-less-than. It adds an iterative multiply/divide engine with architectural HI/LO registers. It sits in the EX stage, and its `busy` output stalls the pipeline while a multiply or divide is in flight.

## Interface
- `WIDTH`, 32, datapath width (≥4, even)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: issue strobe; sampled only when `busy`=0
- `alu_op` in 4: operation code (`alu_op_e`)
- `src_a`, `src_b` in WIDTH: operands, sampled with `start`
- `result` out WIDTH: registered result
- `zero` out 1: `result`==0, registered with `result`
- `overflow` out 1: signed overflow for ADD/SUB only, else 0
- `busy` out 1: multiply/divide in progress
- `done` out 1: one-cycle pulse; `result`/`zero`/`overflow` valid
- `hi`, `lo` out WIDTH: HI/LO registers

## Operation
- Op codes:
  - 0000 AND, 0001 OR, 0011 XOR, 0100 NOR
  - 0010 ADD, 0110 SUB
  - 0111 SLT (signed), 0101 SLTU
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU
  - 1100 MFHI, 1101 MFLO
  - Others are illegal.
- Simple ops (logic, ADD, SUB, SLT, SLTU, MFHI, MFLO):
  - Computed and registered at the issuing edge.
  - `hi`/`lo` unchanged.
- MULT/MULTU: `{hi,lo}` = full 2·WIDTH-bit product; `result` = low half of the product.
- DIV/DIVU: `lo` = quotient, `hi` = remainder, `result` = quotient.
- Signed mul/div:
  - Operate on magnitudes; the sign fix-up is applied in the final cycle.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Divide by zero: `lo` = all ones, `hi` = `src_a`, `result` = all ones; completes in 1 cycle.
- Most-negative ÷ −1 (DIV): `lo` = most-negative, `hi` = 0; no flag.
- Illegal op: `result` = 0, `zero` = 1, `overflow` = 0, `hi`/`lo` unchanged; completes in 1 cycle.
- State machine `IDLE → MUL | DIV → IDLE`:
  - Counter runs 0..WIDTH−1.
  - Multiply: shift-add, one bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
- `start` while `busy`=1 is ignored; no queueing.
- Reset (mid-operation included) aborts any op and returns to IDLE. Reset values:
  - `result`, `hi`, `lo` = 0
  - `zero` = 1
  - `overflow`, `busy`, `done` = 0

## Timing
- Issue edge T = rising edge with `start`=1 and `busy`=0.
- Simple, illegal and divide-by-zero ops:
  - Outputs update at T.
  - `done`=1 during cycle T..T+1.
  - `busy` stays 0.
- Multiply/divide:
  - `busy`=1 from T to edge T+WIDTH.
  - At T+WIDTH, `hi`/`lo`/`result` update, `busy` falls and `done`=1 for one cycle.
  - Latency = WIDTH cycles.
- Back-to-back: a new `start` is accepted in the same cycle `done` is high.
- MFHI/MFLO issued in the `done` cycle return the new HI/LO.
- `result` holds its value between ops; `done` is never high for two consecutive cycles unless two ops are issued back to back.

## Configuration
- `ALU_MULDIV_DIV_EN` defined: divider path present; DIV/DIVU behave as specified.
- Not defined:
  - No divider logic.
  - DIV/DIVU are treated as illegal ops: 1-cycle `done`, `result`=0, `hi`/`lo` unchanged.
  - State machine has no DIV state.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum (4-bit codes above)
  - `muldiv_state_e` enum
  - `ALU_WIDTH_DEF` = 32
- Sub-module `muldiv_iter`: magnitude shift-add/restoring engine with counter, sign fix-up and HI/LO outputs. The top-level contains the simple-op datapath and the output registers.

## Test plan
- Reset mid-MULT: `rst` pulsed at cycle 5 of MULT → `busy`=0, `hi`=`lo`=0, `zero`=1, no `done`.
- ADD 0x7FFFFFFF+1 → `result`=0x80000000, `overflow`=1, `done` next cycle. SUB 5−5 → `zero`=1.
- SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
- MULT −3×7:
  - `busy` for 32 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - `start` during `busy` is ignored.
  - MFLO in the `done` cycle returns 0xFFFFFFEB.
- DIV −7÷2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 7÷0 → `lo`=0xFFFFFFFF, `hi`=7 in 1 cycle.
  - Without `ALU_MULDIV_DIV_EN`: `result`=0, `hi`/`lo` unchanged.
- WIDTH=8 build: MULTU 0xFF×0xFF → `hi`=0xFE, `lo`=0x01 after 8 cycles.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared types for the alu_muldiv block: opcodes, multiply/divide FSM states, default width.
// Optional divider support is selected with ALU_MULDIV_DIV_EN.
package alu_pkg;

    localparam int ALU_WIDTH_DEF = 32;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_NOR   = 4'b0100,
        OP_SLTU  = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_MFHI  = 4'b1100,
        OP_MFLO  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1
`ifdef ALU_MULDIV_DIV_EN
        ,
        MD_DIV  = 2'd2
`endif
    } muldiv_state_e;

endpackage

// File: rtl/alu_muldiv_if.sv
// Issue/result bundle between the EX-stage control (master) and alu_muldiv (slave).
interface alu_muldiv_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH_DEF
);
    logic             start;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, alu_op, src_a, src_b,
        input  result, zero, overflow, busy, done, hi, lo
    );

    modport slave (
        input  start, alu_op, src_a, src_b,
        output result, zero, overflow, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative magnitude multiply (shift-add) and, with ALU_MULDIV_DIV_EN, restoring divide.
// Final-cycle HI/LO (sign fixed) are presented combinationally alongside fin_o.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
`ifdef ALU_MULDIV_DIV_EN
    input  logic             is_div_i,
`endif
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             fin_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    muldiv_state_e    state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, q_q, b_q;
    logic             neg_q;
`ifdef ALU_MULDIV_DIV_EN
    logic             rneg_q;
    logic [WIDTH:0]   trial;
    logic             ge;
`endif

    logic [WIDTH-1:0]   a_mag, b_mag, acc_d, q_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;

    assign a_mag  = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag  = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    assign busy_o = (state_q != MD_IDLE);
    assign fin_o  = busy_o && (cnt_q == LAST);

    // {acc_q,q_q} is the product register for multiply and {remainder,dividend/quotient} for divide
    always_comb begin
        mul_sum = {1'b0, acc_q} + {1'b0, (q_q[0] ? b_q : {WIDTH{1'b0}})};
        acc_d   = mul_sum[WIDTH:1];
        q_d     = {mul_sum[0], q_q[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
        trial = {acc_q, q_q[WIDTH-1]};
        ge    = (trial >= {1'b0, b_q});
        if (state_q == MD_DIV) begin
            acc_d = ge ? (trial[WIDTH-1:0] - b_q) : trial[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], ge};
        end
`endif
        prod = {acc_d, q_d};
        if (neg_q) begin
            prod = -prod;
        end
        hi_o = prod[2*WIDTH-1:WIDTH];
        lo_o = prod[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
        if (state_q == MD_DIV) begin
            lo_o = neg_q  ? -q_d   : q_d;
            hi_o = rneg_q ? -acc_d : acc_d;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            rneg_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        q_q     <= a_mag;
                        b_q     <= b_mag;
                        neg_q   <= is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        state_q <= MD_MUL;
`ifdef ALU_MULDIV_DIV_EN
                        rneg_q  <= is_signed_i & a_i[WIDTH-1];
                        if (is_div_i) begin
                            state_q <= MD_DIV;
                        end
`endif
                    end
                end
                default: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= MD_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle R-type ops plus iterative MULT/DIV with HI/LO registers.
// Divider present only when ALU_MULDIV_DIV_EN is defined; otherwise DIV/DIVU act as illegal ops.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    alu_muldiv_if.slave bus
);
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;

    logic [WIDTH-1:0] a, b, sum, diff, simple_res, md_hi, md_lo;
    logic             issue, md_start, md_signed, md_busy, md_fin, simple_ovf;
`ifdef ALU_MULDIV_DIV_EN
    logic             md_div, div_zero;
`endif

    assign a     = bus.src_a;
    assign b     = bus.src_b;
    assign sum   = a + b;
    assign diff  = a - b;
    assign issue = bus.start && !md_busy;

    always_comb begin
        simple_res = '0;
        simple_ovf = 1'b0;
        md_start   = 1'b0;
        md_signed  = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
        md_div     = 1'b0;
        div_zero   = 1'b0;
`endif
        case (bus.alu_op)
            OP_AND:  simple_res = a & b;
            OP_OR:   simple_res = a | b;
            OP_XOR:  simple_res = a ^ b;
            OP_NOR:  simple_res = ~(a | b);
            OP_ADD: begin
                simple_res = sum;
                simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                simple_res = diff;
                simple_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MULT: begin
                md_start  = 1'b1;
                md_signed = 1'b1;
            end
            OP_MULTU: md_start = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
            OP_DIV, OP_DIVU: begin
                md_signed = (bus.alu_op == OP_DIV);
                if (b == '0) begin
                    div_zero = 1'b1;
                end else begin
                    md_start = 1'b1;
                    md_div   = 1'b1;
                end
            end
`endif
            OP_MFHI: simple_res = hi_q;
            OP_MFLO: simple_res = lo_q;
            default: simple_res = '0;
        endcase
    end

    // Engine completion and a new issue never coincide: issue requires busy low
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        if (md_fin) begin
            hi_d     = md_hi;
            lo_d     = md_lo;
            result_d = md_lo;
            zero_d   = (md_lo == '0);
            ovf_d    = 1'b0;
            done_d   = 1'b1;
        end else if (issue && !md_start) begin
            result_d = simple_res;
            zero_d   = (simple_res == '0);
            ovf_d    = simple_ovf;
            done_d   = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
            if (div_zero) begin
                result_d = '1;
                zero_d   = 1'b0;
                ovf_d    = 1'b0;
                lo_d     = '1;
                hi_d     = a;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (issue && md_start),
`ifdef ALU_MULDIV_DIV_EN
        .is_div_i   (md_div),
`endif
        .is_signed_i(md_signed),
        .a_i        (a),
        .b_i        (b),
        .busy_o     (md_busy),
        .fin_o      (md_fin),
        .hi_o       (md_hi),
        .lo_o       (md_lo)
    );

    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;
    assign bus.busy     = md_busy;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
